key_press_detect: RTL and testbench
===================================

Name: key_press_detect

Overview:
- Upstream front-end for the push-button that starts EEPROM transactions.
- Synchronises the raw button and debounces press and release.
- Classifies each press as short or long.
- Emits single-cycle pulses: key_short feeds the EEPROM controller's start input; key_long is for the alternate command path.

Parameters:
DEBOUNCE_CYC, 1_000_000, stable cycles required to accept a press or release (20 ms at 50 MHz); legal range ≥ 2
LONG_CYC, 50_000_000, cycles after debounced press at which a long press is declared (1 s at 50 MHz); legal range ≥ 2
ACTIVE_LOW, 1, 1: button reads 0 when pressed; 0: reads 1 when pressed

Ports:
clk  input  1  system clock
rst  input  1  asynchronous active-high reset
key  input  1  raw, asynchronous, bouncing button level
key_level  output  1  debounced pressed state, 1 = pressed
key_short  output  1  one-cycle pulse: a press released before reaching LONG_CYC
key_long  output  1  one-cycle pulse: press held for LONG_CYC cycles; fires while still held
busy  output  1  high whenever the state is not IDLE

Behaviour:
- Reset is asynchronous and active-high. It forces all of the following:
  - state = IDLE; all counters = 0; long_flag = 0
  - key_level = 0, key_short = 0, key_long = 0, busy = 0
  - both synchroniser flops = the idle level (1 if ACTIVE_LOW, else 0)
- Synchroniser: 2-flop chain on key. pressed = (sync2 == active level).
- Counter width is $clog2 of the larger of DEBOUNCE_CYC and LONG_CYC. Counters never wrap; every terminal compare is equality with N-1.
- State machine (all transitions on the rising edge of clk):
  - IDLE: if pressed, go to PRESS_DB with cnt = 0.
  - PRESS_DB:
    - if !pressed, go to IDLE (glitch rejected, no output);
    - else if cnt == DEBOUNCE_CYC-1, go to HELD, set key_level = 1, hold_cnt = 0, long_flag = 0;
    - else cnt++.
  - HELD:
    - if !pressed, go to RELEASE_DB with cnt = 0;
    - else if hold_cnt == LONG_CYC-1, assert key_long for this one cycle, set long_flag = 1, go to LONG_HELD;
    - else hold_cnt++.
  - LONG_HELD: if !pressed, go to RELEASE_DB with cnt = 0. No further key_long pulses for this press.
  - RELEASE_DB:
    - if pressed (release bounce), return to LONG_HELD if long_flag, else to HELD. hold_cnt keeps its value; it is frozen while in RELEASE_DB.
    - else if cnt == DEBOUNCE_CYC-1, go to IDLE, set key_level = 0, and assert key_short for one cycle iff long_flag == 0;
    - else cnt++.
- Latency, measured from key changing between edges (edge 1 = first sampling edge):
  - key_level rises at edge DEBOUNCE_CYC+3.
  - key_long pulses at edge DEBOUNCE_CYC+LONG_CYC+3 if held continuously.
  - key_level falls, and key_short pulses, at edge DEBOUNCE_CYC+3 after release.
- Glitch rejection:
  - an active pulse of ≤ DEBOUNCE_CYC cycles produces no output;
  - an active pulse of ≥ DEBOUNCE_CYC+1 cycles is accepted.
  - The same rule applies to inactive glitches during a press.
- Pulse exclusivity:
  - at most one of key_short / key_long per press;
  - key_short and key_long are never high in the same cycle;
  - all outputs are registered.
- Reset mid-press: return immediately to reset values. No pulse is emitted on or after reset release unless a fresh press is debounced from IDLE.

Test Plan:
(All scenarios use DEBOUNCE_CYC=4, LONG_CYC=20, ACTIVE_LOW=1.)
- Clean short press: key low for 12 cycles then high.
  - key_level=1 at edge 7;
  - key_level=0 and a single key_short pulse at release edge 7;
  - key_long never asserted.
- Long press: key low for 40 cycles.
  - key_long pulse exactly at edge 27, once only;
  - on release, key_level falls with no key_short.
- Glitch rejection:
  - key low for 4 cycles: no key_level, no pulses, busy returns to 0;
  - key low for 5 cycles: key_level asserts and key_short follows.
- Release bounce: during HELD, key high for 3 cycles then low again.
  - key_level stays 1, no key_short;
  - hold_cnt resumes without reset, so key_long fires 3+ cycles later than it would on an uninterrupted hold (frozen, not reset).
- Reset mid-press: assert rst asynchronously, between edges, while in HELD with hold_cnt=10.
  - all outputs 0 immediately;
  - after rst deasserts with key still low, a new press is debounced from IDLE (key_level at edge 7 relative to rst release).
- ACTIVE_LOW=0 build: repeat the short-press scenario with polarity inverted; identical timing required.

Source files
------------

// File: rtl/key_press_detect.sv
// ============================================================================
// Module   : key_press_detect
// Brief    : Push-button front end. Synchronises, debounces and classifies
//            presses into single-cycle short/long pulses.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module key_press_detect #(
    parameter int DEBOUNCE_CYC = 1_000_000,
    parameter int LONG_CYC     = 50_000_000,
    parameter bit ACTIVE_LOW   = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic key,
    output logic key_level,
    output logic key_short,
    output logic key_long,
    output logic busy
);

    localparam int c_MAX_CYC = (DEBOUNCE_CYC > LONG_CYC) ? DEBOUNCE_CYC : LONG_CYC;
    localparam int c_CNT_W   = $clog2(c_MAX_CYC);

    localparam logic [c_CNT_W-1:0] c_DB_LAST   = c_CNT_W'(DEBOUNCE_CYC - 1);
    localparam logic [c_CNT_W-1:0] c_LONG_LAST = c_CNT_W'(LONG_CYC - 1);
    localparam logic               c_IDLE_LVL  = ACTIVE_LOW ? 1'b1 : 1'b0;

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_PRESS_DB   = 3'd1,
        S_HELD       = 3'd2,
        S_LONG_HELD  = 3'd3,
        S_RELEASE_DB = 3'd4
    } state_t;

    state_t               state_q,     state_d;
    logic [c_CNT_W-1:0]   cnt_q,       cnt_d;
    logic [c_CNT_W-1:0]   hold_cnt_q,  hold_cnt_d;
    logic                 long_flag_q, long_flag_d;
    logic                 key_level_q, key_level_d;
    logic                 key_short_q, key_short_d;
    logic                 key_long_q,  key_long_d;
    logic                 busy_q,      busy_d;
    logic                 sync1_q,     sync1_d;
    logic                 sync2_q,     sync2_d;
    logic                 w_pressed;

    assign sync1_d   = key;
    assign sync2_d   = sync1_q;
    assign w_pressed = (sync2_q != c_IDLE_LVL);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        hold_cnt_d  = hold_cnt_q;
        long_flag_d = long_flag_q;
        key_level_d = key_level_q;
        key_short_d = 1'b0;
        key_long_d  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (w_pressed) begin
                    state_d = S_PRESS_DB;
                    cnt_d   = '0;
                end
            end
            S_PRESS_DB: begin
                if (!w_pressed) begin
                    state_d = S_IDLE;
                end else if (cnt_q == c_DB_LAST) begin
                    state_d     = S_HELD;
                    key_level_d = 1'b1;
                    hold_cnt_d  = '0;
                    long_flag_d = 1'b0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_HELD: begin
                if (!w_pressed) begin
                    state_d = S_RELEASE_DB;
                    cnt_d   = '0;
                end else if (hold_cnt_q == c_LONG_LAST) begin
                    state_d     = S_LONG_HELD;
                    key_long_d  = 1'b1;
                    long_flag_d = 1'b1;
                end else begin
                    hold_cnt_d = hold_cnt_q + 1'b1;
                end
            end
            S_LONG_HELD: begin
                if (!w_pressed) begin
                    state_d = S_RELEASE_DB;
                    cnt_d   = '0;
                end
            end
            S_RELEASE_DB: begin
                // A release bounce resumes the hold with hold_cnt frozen, not cleared.
                if (w_pressed) begin
                    state_d = long_flag_q ? S_LONG_HELD : S_HELD;
                end else if (cnt_q == c_DB_LAST) begin
                    state_d     = S_IDLE;
                    key_level_d = 1'b0;
                    key_short_d = !long_flag_q;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            hold_cnt_q  <= '0;
            long_flag_q <= 1'b0;
            key_level_q <= 1'b0;
            key_short_q <= 1'b0;
            key_long_q  <= 1'b0;
            busy_q      <= 1'b0;
            sync1_q     <= c_IDLE_LVL;
            sync2_q     <= c_IDLE_LVL;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            hold_cnt_q  <= hold_cnt_d;
            long_flag_q <= long_flag_d;
            key_level_q <= key_level_d;
            key_short_q <= key_short_d;
            key_long_q  <= key_long_d;
            busy_q      <= busy_d;
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
        end
    end

    assign key_level = key_level_q;
    assign key_short = key_short_q;
    assign key_long  = key_long_q;
    assign busy      = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_key_press_detect.sv
// ============================================================================
// Module   : tb_key_press_detect
// Brief    : Scoreboard bench for key_press_detect, one active-low and one
//            active-high instance sharing clock and reset.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_key_press_detect;

    localparam int c_DB   = 4;
    localparam int c_LONG = 20;

    localparam int K_RISE  = 0;
    localparam int K_FALL  = 1;
    localparam int K_SHORT = 2;
    localparam int K_LONG  = 3;

    typedef struct {
        int dut;
        int kind;
        int cyc;
    } ev_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] key;
    logic [1:0] lvl, sh, lg, bsy;

    int   cyc   = 0;
    int   total = 0;
    int   bad   = 0;
    ev_t  q[$];
    logic [1:0] prev_lvl = 2'b00;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    key_press_detect #(.DEBOUNCE_CYC(c_DB), .LONG_CYC(c_LONG), .ACTIVE_LOW(1'b1)) u_dut_lo (
        .clk(clk), .rst(rst), .key(key[0]),
        .key_level(lvl[0]), .key_short(sh[0]), .key_long(lg[0]), .busy(bsy[0])
    );

    key_press_detect #(.DEBOUNCE_CYC(c_DB), .LONG_CYC(c_LONG), .ACTIVE_LOW(1'b0)) u_dut_hi (
        .clk(clk), .rst(rst), .key(key[1]),
        .key_level(lvl[1]), .key_short(sh[1]), .key_long(lg[1]), .busy(bsy[1])
    );

    // Turn observed output activity into events and match them against the queue.
    always @(negedge clk) begin : mon
        int  kinds [3];
        int  n;
        ev_t e;
        if (rst) begin
            prev_lvl = lvl;
        end else begin
            for (int d = 0; d < 2; d++) begin
                n = 0;
                if (lvl[d] !== prev_lvl[d]) begin
                    kinds[n] = lvl[d] ? K_RISE : K_FALL;
                    n = n + 1;
                end
                if (sh[d] === 1'b1) begin
                    kinds[n] = K_SHORT;
                    n = n + 1;
                end
                if (lg[d] === 1'b1) begin
                    kinds[n] = K_LONG;
                    n = n + 1;
                end
                if (sh[d] === 1'b1 && lg[d] === 1'b1) begin
                    total++;
                    bad++;
                    $display("FAIL exclusive dut=%0d cyc=%0d: short=%b long=%b, required not both", d, cyc, sh[d], lg[d]);
                end
                for (int i = 0; i < n; i++) begin
                    total++;
                    if (q.size() == 0) begin
                        bad++;
                        $display("FAIL unexpected_event dut=%0d kind=%0d cyc=%0d, required none", d, kinds[i], cyc);
                    end else begin
                        e = q.pop_front();
                        if (e.dut != d || e.kind != kinds[i] || e.cyc != cyc) begin
                            bad++;
                            $display("FAIL event: got dut=%0d kind=%0d cyc=%0d, required dut=%0d kind=%0d cyc=%0d",
                                     d, kinds[i], cyc, e.dut, e.kind, e.cyc);
                        end
                    end
                end
                prev_lvl[d] = lvl[d];
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push_ev(input int d, input int k, input int c);
        ev_t e;
        e.dut  = d;
        e.kind = k;
        e.cyc  = c;
        q.push_back(e);
    endtask

    task automatic drain(input string name);
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL %s_pending: %0d expected events never seen, required 0", name, q.size());
        end
        q.delete();
    endtask

    task automatic test_reset;
        rst = 1'b1;
        key = 2'b01;
        #1;
        total++;
        if ({lvl, sh, lg, bsy} !== 8'h00) begin
            bad++;
            $display("FAIL reset_outputs: got %h, required 00", {lvl, sh, lg, bsy});
        end
        tick(3);
        rst = 1'b0;
        tick(5);
        drain("reset");
    endtask

    task automatic test_short;
        int e0, e1;
        e0 = cyc;
        key[0] = 1'b0;
        push_ev(0, K_RISE, e0 + 7);
        tick(4);
        total++;
        if (bsy[0] !== 1'b1) begin
            bad++;
            $display("FAIL short_busy: got %b, required 1", bsy[0]);
        end
        tick(8);
        e1 = cyc;
        key[0] = 1'b1;
        push_ev(0, K_FALL,  e1 + 7);
        push_ev(0, K_SHORT, e1 + 7);
        tick(12);
        total++;
        if (bsy[0] !== 1'b0) begin
            bad++;
            $display("FAIL short_busy_idle: got %b, required 0", bsy[0]);
        end
        drain("short");
    endtask

    task automatic test_long;
        int e0, e1;
        e0 = cyc;
        key[0] = 1'b0;
        push_ev(0, K_RISE, e0 + 7);
        push_ev(0, K_LONG, e0 + 27);
        tick(40);
        e1 = cyc;
        key[0] = 1'b1;
        push_ev(0, K_FALL, e1 + 7);
        tick(12);
        drain("long");
    endtask

    task automatic test_glitch;
        int e0, e1;
        key[0] = 1'b0;
        tick(4);
        key[0] = 1'b1;
        tick(10);
        total++;
        if (bsy[0] !== 1'b0 || lvl[0] !== 1'b0) begin
            bad++;
            $display("FAIL glitch4_idle: busy=%b level=%b, required 0 0", bsy[0], lvl[0]);
        end
        drain("glitch4");
        e0 = cyc;
        key[0] = 1'b0;
        push_ev(0, K_RISE, e0 + 7);
        tick(5);
        e1 = cyc;
        key[0] = 1'b1;
        push_ev(0, K_FALL,  e1 + 7);
        push_ev(0, K_SHORT, e1 + 7);
        tick(14);
        drain("glitch5");
    endtask

    task automatic test_release_bounce;
        int e0, e1;
        e0 = cyc;
        key[0] = 1'b0;
        push_ev(0, K_RISE, e0 + 7);
        // Four hold edges are lost to the bounce, pushing key_long from 27 to 31.
        push_ev(0, K_LONG, e0 + 31);
        tick(10);
        key[0] = 1'b1;
        tick(3);
        key[0] = 1'b0;
        tick(27);
        e1 = cyc;
        key[0] = 1'b1;
        push_ev(0, K_FALL, e1 + 7);
        tick(12);
        drain("bounce");
    endtask

    task automatic test_reset_mid_press;
        int e0, er, e1;
        e0 = cyc;
        key[0] = 1'b0;
        push_ev(0, K_RISE, e0 + 7);
        tick(17);
        #1;
        rst = 1'b1;
        #1;
        total++;
        if ({lvl, sh, lg, bsy} !== 8'h00) begin
            bad++;
            $display("FAIL midreset_outputs: got %h, required 00", {lvl, sh, lg, bsy});
        end
        drain("midreset_pre");
        tick(3);
        rst = 1'b0;
        er = cyc;
        push_ev(0, K_RISE, er + 7);
        tick(12);
        e1 = cyc;
        key[0] = 1'b1;
        push_ev(0, K_FALL,  e1 + 7);
        push_ev(0, K_SHORT, e1 + 7);
        tick(12);
        drain("midreset");
    endtask

    task automatic test_active_high;
        int e0, e1;
        e0 = cyc;
        key[1] = 1'b1;
        push_ev(1, K_RISE, e0 + 7);
        tick(12);
        e1 = cyc;
        key[1] = 1'b0;
        push_ev(1, K_FALL,  e1 + 7);
        push_ev(1, K_SHORT, e1 + 7);
        tick(12);
        total++;
        if (bsy[1] !== 1'b0) begin
            bad++;
            $display("FAIL active_high_busy: got %b, required 0", bsy[1]);
        end
        drain("active_high");
    endtask

    initial begin
        test_reset();
        test_short();
        test_long();
        test_glitch();
        test_release_bounce();
        test_reset_mid_press();
        test_active_high();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
